// File: rtl/video_pkg.sv
// Raster timing constants and the small bundles shared by the video path.
package video_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL  = 800;
  localparam int VGA_V_TOTAL  = 525;

  localparam int MAX_TOTAL    = 1024;
  localparam int MAX_PIX_LAT  = 4;

  typedef struct packed {
    logic [7:0] r, g, b;
  } rgb_t;

  typedef struct packed {
    logic hs, vs, de;
  } vctl_t;

  function automatic logic in_win(
    input logic [9:0] v,
    input logic [9:0] lo,
    input logic [9:0] hi
  );
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/sig_delay.sv
// Fixed-depth shift register with a synchronous reset to a chosen idle value.
module sig_delay #(
  parameter int              WIDTH   = 1,
  parameter int              DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("sig_delay: DEPTH must be >= 1");
  end

  logic [WIDTH-1:0] r_sr [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_sr[i] <= RST_VAL;
      end
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/video_timing.sv
// Raster counters for the renderer plus an aligned rgb/sync/de pixel stream.
module video_timing
  import video_pkg::*;
#(
  parameter int H_ACTIVE  = VGA_H_ACTIVE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_ACTIVE  = VGA_V_ACTIVE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int PIX_LAT   = 0
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] x,
  output logic [9:0] y,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic [7:0] out_r,
  output logic [7:0] out_g,
  output logic [7:0] out_b,
  output logic       out_hsync,
  output logic       out_vsync,
  output logic       out_de,
  output logic       frame_start,
  output logic       line_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
    $error("video_timing: H_TOTAL/V_TOTAL exceed 1024");
  end
  if (PIX_LAT < 0 || PIX_LAT > MAX_PIX_LAT) begin : g_bad_lat
    $error("video_timing: PIX_LAT out of range 0..4");
  end

  localparam logic [9:0] HT_M1 = 10'(H_TOTAL - 1);
  localparam logic [9:0] VT_M1 = 10'(V_TOTAL - 1);
  localparam logic [9:0] HA_W  = 10'(H_ACTIVE);
  localparam logic [9:0] VA_W  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_LO = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_HI = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_LO = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_HI = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam vctl_t CTL_IDLE = '{
    hs: ~HSYNC_POL,
    vs: ~VSYNC_POL,
    de: 1'b0
  };

  logic [9:0] r_x;
  logic [9:0] r_y;
  rgb_t       r_rgb;
  logic       w_x_wrap;
  vctl_t      w_ctl0;
  vctl_t      w_ctl_out;

  assign w_x_wrap = (r_x == HT_M1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else begin
      r_x <= w_x_wrap ? '0 : r_x + 10'd1;
      if (w_x_wrap) begin
        r_y <= (r_y == VT_M1) ? '0 : r_y + 10'd1;
      end
    end
  end

  assign w_ctl0.de = (r_x < HA_W) && (r_y < VA_W);
  assign w_ctl0.hs = in_win(r_x, HS_LO, HS_HI) ? HSYNC_POL : ~HSYNC_POL;
  assign w_ctl0.vs = in_win(r_y, VS_LO, VS_HI) ? VSYNC_POL : ~VSYNC_POL;

  // one extra stage beyond the renderer latency matches the rgb register
  sig_delay #(
    .WIDTH   ($bits(vctl_t)),
    .DEPTH   (PIX_LAT + 1),
    .RST_VAL (CTL_IDLE)
  ) u_ctl_dly (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (w_ctl0),
    .o_q   (w_ctl_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rgb <= '0;
    end else begin
      r_rgb <= rgb_t'{r, g, b};
    end
  end

  assign x           = r_x;
  assign y           = r_y;
  assign out_hsync   = w_ctl_out.hs;
  assign out_vsync   = w_ctl_out.vs;
  assign out_de      = w_ctl_out.de;
  assign out_r       = w_ctl_out.de ? r_rgb.r : 8'h00;
  assign out_g       = w_ctl_out.de ? r_rgb.g : 8'h00;
  assign out_b       = w_ctl_out.de ? r_rgb.b : 8'h00;
  assign line_start  = !rst && (r_x == '0);
  assign frame_start = line_start && (r_y == '0);

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing on a shrunken raster with a 2-cycle renderer.
module tb_video_timing;

  localparam int HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int VA = 12, VF = 2, VS = 2, VB = 4;
  localparam int L  = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] r = 8'h0, g = 8'h0, b = 8'h0;
  logic [9:0] x, y;
  logic [7:0] out_r, out_g, out_b;
  logic       out_hsync, out_vsync, out_de;
  logic       frame_start, line_start;

  int          total = 0;
  int          bad   = 0;
  int          n     = 0;
  int          mode  = 2;
  logic [23:0] drv [8];
  logic [9:0]  xh  [8];
  logic [9:0]  yh  [8];

  video_timing #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .HSYNC_POL (1'b0), .VSYNC_POL (1'b0), .PIX_LAT (L)
  ) dut (
    .clk (clk), .rst (rst),
    .x (x), .y (y),
    .r (r), .g (g), .b (b),
    .out_r (out_r), .out_g (out_g), .out_b (out_b),
    .out_hsync (out_hsync), .out_vsync (out_vsync),
    .out_de (out_de),
    .frame_start (frame_start), .line_start (line_start)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  // reference raster: cycle c after release shows pixel (c mod HT, line)
  function automatic int mx(input int c);
    return c % HT;
  endfunction

  function automatic int my(input int c);
    return (c / HT) % VT;
  endfunction

  function automatic bit mde(input int c);
    return (c >= 0) && (mx(c) < HA) && (my(c) < VA);
  endfunction

  function automatic bit mhs(input int c);
    return (c >= 0) && (mx(c) >= HA + HF) && (mx(c) < HA + HF + HS);
  endfunction

  function automatic bit mvs(input int c);
    return (c >= 0) && (my(c) >= VA + VF) && (my(c) < VA + VF + VS);
  endfunction

  function automatic logic [23:0] exp_rgb(input int c);
    return mde(c - L - 1) ? drv[(c - 1) % 8] : 24'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  // renderer: mode 0 = 2-stage pipe of x/y, 1 = all-ones, 2 = random
  task automatic drive();
    xh[n % 8] = x;
    yh[n % 8] = y;
    case (mode)
      0: begin
        if (n >= L) begin
          r = xh[(n - L) % 8][7:0];
          g = yh[(n - L) % 8][7:0];
        end else begin
          r = 8'h0;
          g = 8'h0;
        end
        b = 8'h5A;
      end
      1: {r, g, b} = 24'hFFFFFF;
      default: {r, g, b} = 24'($urandom);
    endcase
    drv[n % 8] = {r, g, b};
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    mode = 2;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (x !== 10'd0 || y !== 10'd0 || frame_start !== 1'b0 || line_start !== 1'b0) begin
        bad++;
        $display("FAIL reset_cnt x=%0d y=%0d fs=%b ls=%b want 0 0 0 0",
                 x, y, frame_start, line_start);
      end
      total++;
      if ({out_hsync, out_vsync, out_de} !== 3'b110 || {out_r, out_g, out_b} !== 24'h0) begin
        bad++;
        $display("FAIL reset_out hs=%b vs=%b de=%b rgb=%h want 1 1 0 000000",
                 out_hsync, out_vsync, out_de, {out_r, out_g, out_b});
      end
      drive();
    end
    rst = 1'b0;
    n   = 0;
    #1;
    total++;
    if (x !== 10'd0 || y !== 10'd0 || frame_start !== 1'b1 || line_start !== 1'b1) begin
      bad++;
      $display("FAIL reset_release x=%0d y=%0d fs=%b ls=%b want 0 0 1 1",
               x, y, frame_start, line_start);
    end
    drive();
  endtask

  task automatic test_raster(input int frames);
    int fs_cnt = 0;
    for (int i = 0; i < frames * FT; i++) begin
      tick();
      total++;
      if (x !== 10'(mx(n)) || y !== 10'(my(n))) begin
        bad++;
        $display("FAIL raster_xy n=%0d got=%0d,%0d want=%0d,%0d",
                 n, x, y, mx(n), my(n));
      end
      total++;
      if (line_start !== (mx(n) == 0) || frame_start !== (mx(n) == 0 && my(n) == 0)) begin
        bad++;
        $display("FAIL raster_pulse n=%0d ls=%b fs=%b want %b %b", n,
                 line_start, frame_start, mx(n) == 0, mx(n) == 0 && my(n) == 0);
      end
      if (frame_start === 1'b1) fs_cnt++;
      drive();
    end
    total++;
    if (fs_cnt !== frames) begin
      bad++;
      $display("FAIL raster_fs_count got=%0d want=%0d", fs_cnt, frames);
    end
  endtask

  task automatic test_sync();
    int   hs_low = 0, vs_low = 0, line_low = 0;
    logic prev_hs = 1'b1;
    for (int i = 0; i < FT; i++) begin
      tick();
      total++;
      if (out_hsync !== !mhs(n - L - 1) || out_vsync !== !mvs(n - L - 1)) begin
        bad++;
        $display("FAIL sync_level n=%0d hs=%b vs=%b want %b %b", n,
                 out_hsync, out_vsync, !mhs(n - L - 1), !mvs(n - L - 1));
      end
      if (!out_hsync) begin
        hs_low++;
        line_low++;
      end
      if (!out_vsync) vs_low++;
      if (prev_hs && !out_hsync) begin
        total++;
        if (xh[(n - L - 1) % 8] !== 10'(HA + HF)) begin
          bad++;
          $display("FAIL sync_lead x_3_before=%0d want=%0d",
                   xh[(n - L - 1) % 8], HA + HF);
        end
      end
      prev_hs = out_hsync;
      if (i % HT == HT - 1) begin
        total++;
        if (line_low !== HS) begin
          bad++;
          $display("FAIL sync_line low=%0d want=%0d", line_low, HS);
        end
        line_low = 0;
      end
      drive();
    end
    total++;
    if (hs_low !== HS * VT || vs_low !== VS * HT) begin
      bad++;
      $display("FAIL sync_frame hs_low=%0d vs_low=%0d want %0d %0d",
               hs_low, vs_low, HS * VT, VS * HT);
    end
  endtask

  task automatic test_de();
    int de_cnt = 0, lines = 0, run;
    run = (out_de === 1'b1) ? -FT : 0;
    for (int i = 0; i < FT; i++) begin
      tick();
      total++;
      if (out_de !== mde(n - L - 1)) begin
        bad++;
        $display("FAIL de_level n=%0d got=%b want=%b", n, out_de, mde(n - L - 1));
      end
      if (out_de === 1'b1) begin
        de_cnt++;
        run++;
      end else if (run != 0) begin
        if (run > 0) begin
          total++;
          if (run !== HA) begin
            bad++;
            $display("FAIL de_run got=%0d want=%0d", run, HA);
          end
          lines++;
        end
        run = 0;
      end
      drive();
    end
    total++;
    if (de_cnt !== HA * VA || lines !== VA) begin
      bad++;
      $display("FAIL de_frame cnt=%0d lines=%0d want %0d %0d",
               de_cnt, lines, HA * VA, VA);
    end
  endtask

  task automatic test_latency();
    int k;
    mode = 0;
    for (int i = 0; i < FT; i++) begin
      tick();
      k = n - L - 1;
      if (i > L && out_de === 1'b1) begin
        total++;
        if (out_r !== 8'(mx(k)) || out_g !== 8'(my(k)) || out_b !== 8'h5A) begin
          bad++;
          $display("FAIL lat_rgb n=%0d got=%h%h%h want=%h%h5a", n,
                   out_r, out_g, out_b, 8'(mx(k)), 8'(my(k)));
        end
      end
      drive();
    end
  endtask

  task automatic test_blank();
    mode = 1;
    for (int i = 0; i < 2 * FT; i++) begin
      if (i == FT) mode = 2;
      tick();
      total++;
      if ({out_r, out_g, out_b} !== exp_rgb(n)) begin
        bad++;
        $display("FAIL blank_rgb n=%0d de=%b got=%h want=%h", n,
                 out_de, {out_r, out_g, out_b}, exp_rgb(n));
      end
      drive();
    end
  endtask

  task automatic test_midframe_reset();
    int guard = 0;
    mode = 2;
    while (!(mx(n) == 10 && my(n) == 5) && guard < 2 * FT) begin
      tick();
      drive();
      guard++;
    end
    total++;
    if (x !== 10'd10 || y !== 10'd5) begin
      bad++;
      $display("FAIL midrst_reach x=%0d y=%0d want 10 5", x, y);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (x !== 10'd0 || y !== 10'd0 || frame_start !== 1'b0 || line_start !== 1'b0 ||
          {out_hsync, out_vsync, out_de} !== 3'b110 || {out_r, out_g, out_b} !== 24'h0) begin
        bad++;
        $display("FAIL midrst_hold x=%0d y=%0d fs=%b ls=%b hs=%b vs=%b de=%b rgb=%h",
                 x, y, frame_start, line_start, out_hsync, out_vsync, out_de,
                 {out_r, out_g, out_b});
      end
      drive();
    end
    rst = 1'b0;
    n   = 0;
    #1;
    total++;
    if (x !== 10'd0 || y !== 10'd0 || frame_start !== 1'b1) begin
      bad++;
      $display("FAIL midrst_release x=%0d y=%0d fs=%b want 0 0 1", x, y, frame_start);
    end
    drive();
    for (int j = 1; j <= L + 1; j++) begin
      tick();
      total++;
      if (out_de !== (j == L + 1) || (j <= L && {out_r, out_g, out_b} !== 24'h0)) begin
        bad++;
        $display("FAIL midrst_de j=%0d de=%b rgb=%h want de=%b", j, out_de,
                 {out_r, out_g, out_b}, j == L + 1);
      end
      drive();
    end
  endtask

  initial begin
    test_reset();
    test_raster(2);
    test_sync();
    test_de();
    test_latency();
    test_blank();
    test_midframe_reset();
    test_raster(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
